decode_stage: RTL

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. Holds the IF/ID pipeline register, the 32×32 register file and the main control decoder. Resolves beq/bne/j early in decode and returns the next-PC select, branch target and jump address to fetch. Produces operands and control for the ID/EX register.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/reg_file.sv | 62 ++++++
 rtl/decode_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS decode stage: data/register widths,
// opcode and funct constants, ALU control encodings, next-PC select
// encodings and the packed main-control bundle.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_e;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_dst;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// reg_file
// 32 x 32-bit register file: two combinational read ports, one write port
// written on the rising clock edge, write-through bypass so a read of the
// register being written returns the new value in the same cycle.
// Register 0 is hardwired to zero. Asynchronous active-low clear.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low clear of all registers
//   we         write enable
//   wa, wd     write address / data
//   ra1, ra2   read addresses
//   rd1, rd2   read data (combinational)
module reg_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_W-1:0]  ra1,
    input  logic [REG_W-1:0]  ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

    // Writes to register 0 are dropped so it can never hold a non-zero value.
    always_comb begin
        wr_en = we && (wa != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    // Bypass only fires for non-zero addresses, so reads of $0 stay zero
    // even while a write to $0 is being attempted.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = (wr_en && (ra1 == wa)) ? wd : regs_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = (wr_en && (ra2 == wa)) ? wd : regs_q[ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Instruction-decode stage of a 5-stage MIPS pipeline. Holds the IF/ID
// register, the register file and the main control decoder; resolves
// beq/bne/j in decode and returns the next-PC select and targets to fetch.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   instrF, pc_plus4F        fetched instruction and PC+4
//   StallD                   hold IF/ID (hazard unit)
//   ForwardAD/BD, ALUOutM    branch comparator forwarding from MEM
//   RegWriteW/WriteRegW/ResultW  writeback port into the register file
//   PCSrcD                   00 pc+4, 01 branch, 10 jump
//   PCBranchD, JumpAdd       branch and jump targets
//   RD1D, RD2D, SignImmD     operands for ID/EX
//   RsD, RtD, RdD            register fields
//   RegWriteD ... BranchD    control signals, ALUControlD ALU select
module decode_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instrF,
    input  logic [DATA_W-1:0] pc_plus4F,
    input  logic              StallD,
    input  logic              ForwardAD,
    input  logic              ForwardBD,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic              RegWriteW,
    input  logic [REG_W-1:0]  WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    output logic [1:0]        PCSrcD,
    output logic [DATA_W-1:0] PCBranchD,
    output logic [DATA_W-1:0] JumpAdd,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [DATA_W-1:0] SignImmD,
    output logic [REG_W-1:0]  RsD,
    output logic [REG_W-1:0]  RtD,
    output logic [REG_W-1:0]  RdD,
    output logic              RegWriteD,
    output logic              MemtoRegD,
    output logic              MemWriteD,
    output logic              ALUSrcD,
    output logic              RegDstD,
    output logic              BranchD,
    output logic [2:0]        ALUControlD
);

    logic [DATA_W-1:0]        instr_q, instr_d;
    logic [DATA_W-1:0]        pc_plus4_q, pc_plus4_d;
    logic [5:0]               opcode, funct;
    ctrl_t                    ctrl;
    alu_ctl_e                 alu_ctl;
    logic                     is_beq, is_bne, is_jump;
    logic signed [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0]        cmp_a, cmp_b;
    logic                     taken;
    pcsrc_e                   pcsrc;

    // ---- IF/ID register ----
    // Stall holds; a redirect from this cycle's branch/jump squashes the
    // wrong-path fetch by loading zeros (a bubble).
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (!StallD) begin
            if (pcsrc != PCSRC_PLUS4) begin
                instr_d    = '0;
                pc_plus4_d = '0;
            end else begin
                instr_d    = instrF;
                pc_plus4_d = pc_plus4F;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= '0;
            pc_plus4_q <= '0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    // ---- Decode stage ----
    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];

    // The all-zero word (bubble / reset contents) decodes with every control
    // bit low; it is sll $0,$0,0, which has no architectural effect anyway.
    always_comb begin
        ctrl    = '0;
        alu_ctl = ALU_AND;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (instr_q != '0) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    case (funct)
                        FN_ADD:  alu_ctl = ALU_ADD;
                        FN_SUB:  alu_ctl = ALU_SUB;
                        FN_AND:  alu_ctl = ALU_AND;
                        FN_OR:   alu_ctl = ALU_OR;
                        FN_SLT:  alu_ctl = ALU_SLT;
                        default: alu_ctl = ALU_ADD;
                    endcase
                end
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                alu_ctl         = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_ctl        = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_ctl        = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                alu_ctl     = ALU_SUB;
                is_beq      = 1'b1;
            end
            OP_BNE: begin
                ctrl.branch = 1'b1;
                alu_ctl     = ALU_SUB;
                is_bne      = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (WriteRegW),
        .wd  (ResultW),
        .ra1 (instr_q[25:21]),
        .ra2 (instr_q[20:16]),
        .rd1 (RD1D),
        .rd2 (RD2D)
    );

    assign sign_imm = {{16{instr_q[15]}}, instr_q[15:0]};

    always_comb begin
        cmp_a = ForwardAD ? ALUOutM : RD1D;
        cmp_b = ForwardBD ? ALUOutM : RD2D;
        taken = (is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b));
    end

    // A stalled instruction must not redirect fetch; it resolves again on
    // the cycle the stall releases.
    always_comb begin
        pcsrc = PCSRC_PLUS4;
        if (!StallD) begin
            if (taken) begin
                pcsrc = PCSRC_BRANCH;
            end else if (is_jump) begin
                pcsrc = PCSRC_JUMP;
            end
        end
    end

    assign PCSrcD      = pcsrc;
    assign SignImmD    = sign_imm;
    assign PCBranchD   = pc_plus4_q + {sign_imm[DATA_W-3:0], 2'b00};
    assign JumpAdd     = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    assign RsD         = instr_q[25:21];
    assign RtD         = instr_q[20:16];
    assign RdD         = instr_q[15:11];
    assign RegWriteD   = ctrl.reg_write;
    assign MemtoRegD   = ctrl.mem_to_reg;
    assign MemWriteD   = ctrl.mem_write;
    assign ALUSrcD     = ctrl.alu_src;
    assign RegDstD     = ctrl.reg_dst;
    assign BranchD     = ctrl.branch;
    assign ALUControlD = alu_ctl;

endmodule
